// File: rtl/ddr3_cmd_sched_if.sv
// ddr3_cmd_sched_if: request handshake bus between a client and the DDR3 command scheduler
interface ddr3_cmd_sched_if #(
   parameter int W = 8
);
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [31:0]      req_addr;
   logic [64*W-1:0]  req_wdata;
   modport master (output req_valid, req_we, req_addr, req_wdata, input req_ready);
   modport slave  (input req_valid, req_we, req_addr, req_wdata, output req_ready);
endinterface

// File: rtl/ddr3_cmd_sched.sv
// ddr3_cmd_sched: closed-page BL8 scheduler issuing ACT -> RD/WR(auto-precharge) plus periodic REF
module ddr3_cmd_sched #(
   parameter int W      = 8,
   parameter int T_RCD  = 6,
   parameter int T_RW   = 24,
   parameter int T_RFC  = 128,
   parameter int T_REFI = 6240
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              init_done,
   ddr3_cmd_sched_if.slave   req,
   output logic              cmd_valid,
   output logic              cmd_ras_n,
   output logic              cmd_cas_n,
   output logic              cmd_we_n,
   output logic [2:0]        cmd_ba,
   output logic [15:0]       cmd_addr,
   output logic [64*W-1:0]   wdata,
   output logic [31:0]       waddr,
   output logic              ref_overrun
);
   localparam int TMX = (T_RFC > T_RW) ? ((T_RFC > T_RCD) ? T_RFC : T_RCD)
                                       : ((T_RW > T_RCD) ? T_RW : T_RCD);
   localparam int WCW = $clog2(TMX + 1);
   localparam int RCW = $clog2(T_REFI + 1);
   localparam logic [WCW-1:0] RCD_L = WCW'((T_RCD > 1) ? T_RCD - 2 : 0);
   localparam logic [WCW-1:0] RW_L  = WCW'((T_RW > 1) ? T_RW - 2 : 0);
   localparam logic [WCW-1:0] RFC_L = WCW'((T_RFC > 1) ? T_RFC - 2 : 0);
   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b1011;
   localparam logic [3:0] C_REF = 4'b1001;

   typedef enum logic [2:0] {IDLE, REF, WAIT_RFC, ACT, WAIT_RCD, RW, WAIT_RW} state_t;

   state_t            state_q, state_d;
   logic [WCW-1:0]    wcnt_q, wcnt_d;
   logic [RCW-1:0]    rcnt_q, rcnt_d;
   logic              ref_pend_q, ref_pend_d;
   logic              ovr_q, ovr_d;
   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [64*W-1:0]   wd_q, wd_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [2:0]        ba_q, ba_d;
   logic [15:0]       caddr_q, caddr_d;
   logic [64*W-1:0]   wdata_q, wdata_d;
   logic [31:0]       waddr_q, waddr_d;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = (wcnt_q == '0) ? wcnt_q : wcnt_q - 1'b1;
      rcnt_d     = rcnt_q;
      ref_pend_d = ref_pend_q;
      ovr_d      = ovr_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wd_d       = wd_q;
      case (state_q)
         IDLE: begin
            if (ref_pend_q && init_done) state_d = REF;
            else if (req.req_valid && ready_q) begin
               state_d = ACT;
               we_d    = req.req_we;
               addr_d  = req.req_addr;
               wd_d    = req.req_we ? req.req_wdata : wd_q;
            end
         end
         REF: begin
            state_d = (T_RFC > 1) ? WAIT_RFC : IDLE;
            wcnt_d  = RFC_L;
         end
         WAIT_RFC: state_d = (wcnt_q == '0) ? IDLE : WAIT_RFC;
         ACT: begin
            state_d = (T_RCD > 1) ? WAIT_RCD : RW;
            wcnt_d  = RCD_L;
         end
         WAIT_RCD: state_d = (wcnt_q == '0) ? RW : WAIT_RCD;
         RW: begin
            state_d = (T_RW > 1) ? WAIT_RW : IDLE;
            wcnt_d  = RW_L;
         end
         WAIT_RW: state_d = (wcnt_q == '0) ? IDLE : WAIT_RW;
         default: state_d = IDLE;
      endcase
      // issuing REF retires the pending flag before a same-cycle expiry can re-arm it
      if (state_d == REF) ref_pend_d = 1'b0;
      if (init_done) begin
         rcnt_d = (rcnt_q == '0) ? RCW'(T_REFI - 1) : rcnt_q - 1'b1;
         if (rcnt_q == '0) begin
            ovr_d      = ovr_q | ref_pend_d;
            ref_pend_d = 1'b1;
         end
      end
      ready_d = (state_d == IDLE) && init_done && !ref_pend_d;
      cmd_d   = (state_d == ACT) ? C_ACT : (state_d == RW) ? {3'b110, ~we_d} :
                (state_d == REF) ? C_REF : C_NOP;
      ba_d    = (state_d == ACT || state_d == RW) ? addr_d[9:7] : (state_d == REF) ? 3'b000 : ba_q;
      caddr_d = (state_d == ACT) ? addr_d[25:10] : (state_d == RW) ? {5'b0, 1'b1, addr_d[6:0], 3'b000} :
                (state_d == REF) ? 16'h0000 : caddr_q;
      wdata_d = (state_d == RW && we_d) ? wd_d : wdata_q;
      waddr_d = (state_d == RW) ? addr_d : waddr_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         rcnt_q     <= RCW'(T_REFI - 1);
         ref_pend_q <= 1'b0;
         ovr_q      <= 1'b0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wd_q       <= '0;
         cmd_q      <= C_NOP;
         ba_q       <= '0;
         caddr_q    <= '0;
         wdata_q    <= '0;
         waddr_q    <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
         ref_pend_q <= ref_pend_d;
         ovr_q      <= ovr_d;
         ready_q    <= ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wd_q       <= wd_d;
         cmd_q      <= cmd_d;
         ba_q       <= ba_d;
         caddr_q    <= caddr_d;
         wdata_q    <= wdata_d;
         waddr_q    <= waddr_d;
      end
   end

   assign req.req_ready = ready_q;
   assign {cmd_valid, cmd_ras_n, cmd_cas_n, cmd_we_n} = cmd_q;
   assign cmd_ba      = ba_q;
   assign cmd_addr    = caddr_q;
   assign wdata       = wdata_q;
   assign waddr       = waddr_q;
   assign ref_overrun = ovr_q;
endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// tb_ddr3_cmd_sched: directed vector table plus hand sequences for refresh, init_done and async reset
module tb_ddr3_cmd_sched;
   localparam int W = 2, T_RCD = 3, T_RW = 4, T_RFC = 5, T_REFI = 40;
   localparam int DW = 64 * W;
   localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b1011, C_RD = 4'b1101, C_WR = 4'b1100, C_REF = 4'b1001;

   typedef struct {
      logic          we;
      logic [31:0]   addr;
      logic [DW-1:0] wd;
      logic [2:0]    ba;
      logic [15:0]   row;
      logic [15:0]   caddr;
   } vec_t;

   logic clk = 1'b0, reset_n = 1'b0, init_done = 1'b0;
   logic cmd_valid, cmd_ras_n, cmd_cas_n, cmd_we_n, ref_overrun;
   logic [2:0]    cmd_ba;
   logic [15:0]   cmd_addr;
   logic [DW-1:0] wdata;
   logic [31:0]   waddr;
   int tests = 0, fails = 0;

   ddr3_cmd_sched_if #(.W(W)) rq();

   ddr3_cmd_sched #(.W(W), .T_RCD(T_RCD), .T_RW(T_RW), .T_RFC(T_RFC), .T_REFI(T_REFI)) dut (
      .clk(clk), .reset_n(reset_n), .init_done(init_done), .req(rq),
      .cmd_valid(cmd_valid), .cmd_ras_n(cmd_ras_n), .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n),
      .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .wdata(wdata), .waddr(waddr), .ref_overrun(ref_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] cmdc();
      return {cmd_valid, cmd_ras_n, cmd_cas_n, cmd_we_n};
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      init_done = 1'b0;
      rq.req_valid = 1'b0;
      rq.req_we = 1'b0;
      rq.req_addr = '0;
      rq.req_wdata = '0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, " outs"}, {cmdc(), cmd_ba, cmd_addr, waddr, rq.req_ready, ref_overrun},
          {C_NOP, 3'b000, 16'h0000, 32'h0, 1'b0, 1'b0});
      chk({nm, " wdata"}, wdata, '0);
   endtask

   task automatic drive(input logic we, input logic [31:0] a, input logic [DW-1:0] d);
      rq.req_valid = 1'b1;
      rq.req_we = we;
      rq.req_addr = a;
      rq.req_wdata = d;
   endtask

   initial begin
      vec_t v[5];
      logic [3:0] lg [1:60];
      int a0, a1, r, nref, nact;
      logic bad;
      v[0] = '{1'b1, 32'h0000_0481, 128'hA5A5_0001_DEAD_BEEF_0123_4567_89AB_CDEF, 3'd1, 16'h0001, 16'h0408};
      v[1] = '{1'b0, 32'h03FF_FFFF, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 3'd7, 16'hFFFF, 16'h07F8};
      v[2] = '{1'b1, 32'hFC00_0000, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 3'd0, 16'h0000, 16'h0400};
      v[3] = '{1'b0, 32'h0000_0155, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 3'd2, 16'h0000, 16'h06A8};
      v[4] = '{1'b1, 32'h0123_4567, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0BAD_C0DE, 3'd2, 16'h48D1, 16'h0738};
      for (int i = 0; i < 5; i++) begin
         do_reset();
         chk_reset("reset");
         init_done = 1'b1;
         step();
         chk("ready_up", {rq.req_ready, cmdc()}, {1'b1, C_NOP});
         drive(v[i].we, v[i].addr, v[i].wd);
         step();
         rq.req_valid = 1'b0;
         chk("act", {cmdc(), cmd_ba, cmd_addr, rq.req_ready}, {C_ACT, v[i].ba, v[i].row, 1'b0});
         for (int k = 1; k <= T_RCD + T_RW; k++) begin
            step();
            if (k == T_RCD) begin
               chk("rw_cmd", {cmdc(), cmd_ba, cmd_addr, waddr},
                   {v[i].we ? C_WR : C_RD, v[i].ba, v[i].caddr, v[i].addr});
               chk("rw_wdata", wdata, v[i].we ? v[i].wd : '0);
            end else chk("gap_nop", cmdc(), C_NOP);
            chk("ready_gap", rq.req_ready, k == T_RCD + T_RW);
         end
      end
      // back-to-back reads: ACT-to-ACT spacing
      do_reset();
      init_done = 1'b1;
      step();
      drive(1'b0, 32'h03FF_FFFF, '0);
      a0 = -1;
      a1 = -1;
      for (int n = 1; n <= 30 && a1 < 0; n++) begin
         step();
         if (cmdc() == C_ACT) begin
            if (a0 < 0) a0 = n;
            else a1 = n;
         end
      end
      rq.req_valid = 1'b0;
      chk("act2act", a1 - a0, T_RCD + T_RW + 1);
      // idle refresh timing
      do_reset();
      init_done = 1'b1;
      r = -1;
      for (int n = 1; n <= 60 && r < 0; n++) begin
         step();
         if (cmd_valid) r = n;
      end
      chk("ref_time", r, T_REFI + 1);
      chk("ref_cmd", {cmdc(), cmd_ba, cmd_addr}, {C_REF, 3'b000, 16'h0000});
      for (int k = 1; k <= T_RFC; k++) begin
         step();
         chk("rfc_gap", {cmdc(), rq.req_ready}, {C_NOP, k == T_RFC});
      end
      // expiry during a write, then a request competing with the pending refresh
      do_reset();
      init_done = 1'b1;
      for (int n = 1; n <= 55; n++) begin
         step();
         lg[n] = cmdc();
         if (n == 43) chk("no_accept_pend", rq.req_ready, 1'b0);
         if (n == 35) drive(1'b1, 32'h0000_0481, v[0].wd);
         if (n == 36) rq.req_valid = 1'b0;
         if (n == 40) drive(1'b0, 32'h0000_0155, '0);
         if (n == 50) rq.req_valid = 1'b0;
      end
      chk("seq_act_wr", {lg[36], lg[39]}, {C_ACT, C_WR});
      chk("seq_ref", lg[44], C_REF);
      chk("seq_act_rd", {lg[50], lg[53]}, {C_ACT, C_RD});
      nact = 0;
      for (int n = 36; n <= 55; n++) if (lg[n] != C_NOP) nact++;
      chk("seq_cmd_count", nact, 5);
      // init_done dropped with refresh pending
      do_reset();
      init_done = 1'b1;
      for (int n = 1; n <= 40; n++) step();
      chk("pend_ready", rq.req_ready, 1'b0);
      init_done = 1'b0;
      bad = 1'b0;
      for (int n = 0; n < 2 * T_REFI; n++) begin
         step();
         if (cmd_valid || rq.req_ready || ref_overrun) bad = 1'b1;
      end
      chk("init_hold", bad, 1'b0);
      init_done = 1'b1;
      step();
      chk("ref_after_init", cmdc(), C_REF);
      drive(1'b0, 32'h0000_0155, '0);
      nref = 0;
      nact = 0;
      for (int n = 0; n < 150; n++) begin
         step();
         if (cmdc() == C_REF) nref++;
         if (cmdc() == C_ACT) nact++;
      end
      rq.req_valid = 1'b0;
      chk("traffic_refs", nref >= 3, 1'b1);
      chk("traffic_acts", nact >= 10, 1'b1);
      chk("no_overrun", ref_overrun, 1'b0);
      // async reset during WAIT_RCD
      do_reset();
      init_done = 1'b1;
      step();
      drive(1'b1, 32'h0000_0481, v[0].wd);
      step();
      rq.req_valid = 1'b0;
      for (int k = 0; k < T_RCD + T_RW; k++) step();
      chk("pre_reset_wdata", wdata, v[0].wd);
      drive(1'b0, 32'h0000_0155, '0);
      step();
      rq.req_valid = 1'b0;
      chk("pre_reset_act", cmdc(), C_ACT);
      step();
      #2 reset_n = 1'b0;
      #1 chk_reset("async");
      step();
      reset_n = 1'b1;
      step();
      chk("post_reset_ready", rq.req_ready, 1'b1);
      bad = 1'b0;
      for (int k = 0; k < T_RCD + 2; k++) begin
         step();
         if (cmd_valid) bad = 1'b1;
      end
      chk("post_reset_quiet", bad, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
